multicycle_controller: RTL and testbench

- Parametrised multi-cycle successor of the accumulator-CPU single-cycle controller.
- Sequences FETCH/DECODE/EXEC/WRITEBACK per instruction and drives the same datapath strobes.
- Adds start/halt control, a memory ready handshake and generic accumulator width.
- Sits between the instruction register/accumulator datapath and a memory that may take more than one cycle.

---
 rtl/ctrl_pkg.sv | 27 ++
 rtl/ctrl_decode.sv | 70 +++++++
 rtl/multicycle_controller.sv | 108 ++++++++++
 tb/tb_multicycle_controller.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding and opcode constants for the multi-cycle accumulator controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_STA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_JMP = 3'd4;
    localparam logic [2:0] OP_JEZ = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    // Folds any opcode wider than the ISA into the 3-bit space; everything above 7 behaves as HLT.
    function automatic logic [2:0] op3(input logic [31:0] op);
        return (op > 32'd7) ? OP_HLT : op[2:0];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational strobe decode from the registered state and latched opcode.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int DATA_W   = 13,
    parameter int OPCODE_W = 3
) (
    input  state_t              state,
    input  logic [OPCODE_W-1:0] op_q,
    input  logic [DATA_W-1:0]   ac,
    input  logic                mem_ready,
    output logic                rd_mem,
    output logic                wr_mem,
    output logic                ac_src,
    output logic                ld_ac,
    output logic                ld_imm,
    output logic                pc_src,
    output logic                pc_inc,
    output logic                ld_ir,
    output logic                alu_add,
    output logic                alu_sub,
    output logic                busy,
    output logic                halted
);

    logic [2:0] op;

    assign op     = op3(32'(op_q));
    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

    // Datapath strobes per state; the zero test spans the full accumulator width.
    always_comb begin
        rd_mem  = 1'b0;
        wr_mem  = 1'b0;
        ac_src  = 1'b0;
        ld_ac   = 1'b0;
        ld_imm  = 1'b0;
        pc_src  = 1'b0;
        pc_inc  = 1'b0;
        ld_ir   = 1'b0;
        alu_add = 1'b0;
        alu_sub = 1'b0;
        case (state)
            S_FETCH: begin
                rd_mem = 1'b1;
                ld_ir  = mem_ready;
                pc_inc = mem_ready;
            end
            S_EXEC: begin
                rd_mem  = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
                wr_mem  = (op == OP_STA);
                ac_src  = (op == OP_LDA);
                alu_add = (op == OP_ADD);
                alu_sub = (op == OP_SUB);
                pc_src  = (op == OP_JMP) || ((op == OP_JEZ) && (ac == '0));
                ld_imm  = (op == OP_LDI);
                ld_ac   = (op == OP_LDI);
            end
            S_WB: begin
                ld_ac   = 1'b1;
                ac_src  = (op == OP_LDA);
                alu_add = (op == OP_ADD);
                alu_sub = (op == OP_SUB);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/WB sequencer for the accumulator CPU; CTRL_RETIRE_CNT_EN adds a retired-instruction counter.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int DATA_W   = 13,
    parameter int OPCODE_W = 3
`ifdef CTRL_RETIRE_CNT_EN
   ,parameter int CNT_W    = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   ac,
    input  logic                mem_ready,
    output logic                rd_mem,
    output logic                wr_mem,
    output logic                ac_src,
    output logic                ld_ac,
    output logic                ld_imm,
    output logic                pc_src,
    output logic                pc_inc,
    output logic                ld_ir,
    output logic                alu_add,
    output logic                alu_sub,
    output logic                busy,
    output logic                halted
`ifdef CTRL_RETIRE_CNT_EN
   ,output logic [CNT_W-1:0]    retired
`endif
);

    state_t              state, state_n;
    logic [OPCODE_W-1:0] op_q;
    logic [2:0]          op;
    logic                mem_op;

    assign op     = op3(32'(op_q));
    assign mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);

    // State and latched opcode; the opcode is captured only when the fetch completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_n;
            if (state == S_FETCH && mem_ready)
                op_q <= opcode;
        end
    end

    // Next-state sequencing; memory-touching states wait for mem_ready, start is only seen in IDLE/HALT.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = start ? S_FETCH : S_IDLE;
            S_FETCH:  state_n = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_n = S_EXEC;
            S_EXEC:   state_n = (op == OP_HLT) ? S_HALT :
                                mem_op         ? (mem_ready ? S_WB : S_EXEC) :
                                (op == OP_STA) ? (mem_ready ? S_FETCH : S_EXEC) :
                                                 S_FETCH;
            S_WB:     state_n = S_FETCH;
            S_HALT:   state_n = start ? S_FETCH : S_HALT;
            default:  state_n = S_IDLE;
        endcase
    end

    ctrl_decode #(
        .DATA_W   (DATA_W),
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .state     (state),
        .op_q      (op_q),
        .ac        (ac),
        .mem_ready (mem_ready),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .ac_src    (ac_src),
        .ld_ac     (ld_ac),
        .ld_imm    (ld_imm),
        .pc_src    (pc_src),
        .pc_inc    (pc_inc),
        .ld_ir     (ld_ir),
        .alu_add   (alu_add),
        .alu_sub   (alu_sub),
        .busy      (busy),
        .halted    (halted)
    );

`ifdef CTRL_RETIRE_CNT_EN
    logic retire;

    assign retire = (state == S_WB) ||
                    ((state == S_EXEC) && ((op == OP_STA) ? mem_ready : !mem_op));

    // Counts each instruction on its last cycle; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired <= '0;
        else if (retire)
            retired <= retired + 1'b1;
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of reset, program timing, fetch stall, LDI, JEZ and HALT; CTRL_RETIRE_CNT_EN also checks retired.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [2:0]  opcode;
    logic [12:0] ac;
    logic        rd_mem, wr_mem, ac_src, ld_ac, ld_imm, pc_src, pc_inc, ld_ir, alu_add, alu_sub;
    logic        busy, halted;
`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] retired;
`endif
    logic [9:0]  strb;
    int          checks = 0;
    int          failures = 0;
    int          exp_strb [16] = '{'h000, 'h20C, 'h000, 'h280, 'h0C0, 'h20C, 'h000, 'h202,
                                   'h042, 'h20C, 'h000, 'h100, 'h20C, 'h000, 'h000, 'h000};
    int          busy_m = 'h7FFE;
    int          rd_cnt, ir_cnt, inc_cnt;

    always #5 clk = ~clk;

    assign strb = {rd_mem, wr_mem, ac_src, ld_ac, ld_imm, pc_src, pc_inc, ld_ir, alu_add, alu_sub};

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .ac        (ac),
        .mem_ready (mem_ready),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .ac_src    (ac_src),
        .ld_ac     (ld_ac),
        .ld_imm    (ld_imm),
        .pc_src    (pc_src),
        .pc_inc    (pc_inc),
        .ld_ir     (ld_ir),
        .alu_add   (alu_add),
        .alu_sub   (alu_sub),
        .busy      (busy),
        .halted    (halted)
`ifdef CTRL_RETIRE_CNT_EN
       ,.retired   (retired)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; opcode = 3'd0; ac = 13'd0;
        #1;
        check("reset_strb", 32'(strb), 'h000);
        check("reset_busy", 32'(busy), 0);
        check("reset_halted", 32'(halted), 0);
        @(negedge clk); rst = 1'b0; start = 1'b1;
        #1 check("idle_busy", 32'(busy), 0);
        @(negedge clk); start = 1'b0;
        #1 check("fetch_stall_strb", 32'(strb), 'h200);
        check("fetch_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 check("async_rst_strb", 32'(strb), 'h000);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_halted", 32'(halted), 0);
`ifdef CTRL_RETIRE_CNT_EN
        check("async_rst_retired", 32'(retired), 0);
`endif
        @(negedge clk); rst = 1'b0; mem_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            start = (c == 0);
            opcode = (c < 5) ? 3'd0 : (c < 9) ? 3'd2 : (c < 12) ? 3'd1 : 3'd7;
            #1;
            check($sformatf("prog_strb_c%0d", c), 32'(strb), 32'(exp_strb[c]));
            check($sformatf("prog_busy_c%0d", c), 32'(busy), 32'(busy_m[c]));
            check($sformatf("prog_halted_c%0d", c), 32'(halted), (c == 15) ? 1 : 0);
            @(negedge clk);
        end
`ifdef CTRL_RETIRE_CNT_EN
        check("prog_retired", 32'(retired), 4);
`endif
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("halt_strb_%0d", i), 32'(strb), 'h000);
            check($sformatf("halt_halted_%0d", i), 32'(halted), 1);
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0; opcode = 3'd6;
        rd_cnt = 0; ir_cnt = 0; inc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 3);
            #1;
            if (i == 0) begin
                check("restart_halted", 32'(halted), 0);
                check("restart_rd_mem", 32'(rd_mem), 1);
            end
            rd_cnt += int'(rd_mem);
            ir_cnt += int'(ld_ir);
            inc_cnt += int'(pc_inc);
            @(negedge clk);
        end
        check("stall_rd_cycles", 32'(rd_cnt), 4);
        check("stall_ld_ir_count", 32'(ir_cnt), 1);
        check("stall_pc_inc_count", 32'(inc_cnt), 1);
        #1 check("ldi_exec_strb", 32'(strb), 'h060);
        @(negedge clk); mem_ready = 1'b1; opcode = 3'd5; ac = 13'd0;
        #1 check("jez0_fetch_strb", 32'(strb), 'h20C);
        @(negedge clk);
        #1 check("jez0_decode_strb", 32'(strb), 'h000);
        @(negedge clk);
        #1 check("jez0_exec_strb", 32'(strb), 'h010);
        @(negedge clk); ac = 13'h1000;
        #1 check("jez1_fetch_strb", 32'(strb), 'h20C);
        @(negedge clk);
        @(negedge clk);
        #1 check("jez1_exec_strb", 32'(strb), 'h000);
        check("jez1_exec_busy", 32'(busy), 1);
        @(negedge clk); opcode = 3'd7;
        #1 check("jez1_next_fetch", 32'(strb), 'h20C);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 check("hlt2_halted", 32'(halted), 1);
`ifdef CTRL_RETIRE_CNT_EN
        check("final_retired", 32'(retired), 8);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
